// File: rtl/pc_branch_unit.sv
// Program counter and branch-redirect unit: owns the fetch PC, raises IF/ID squashes on
// taken branches and jumps, handles HLT/resume, and keeps saturating branch statistics.
module pc_branch_unit #(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic              taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  input  logic              resume,
  input  logic              clear_stats,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              flush_if,
  output logic              flush_id,
  output logic              halted,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;

  logic              running;
  logic              active;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  assign running         = (state_q == StRun);
  assign active          = running & ~stall;
  assign redirect        = active & (jump | (branch_valid & taken));
  assign redirect_target = jump ? jump_target : branch_target;
  assign pc_plus1        = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StRun: begin
        // A halt alongside a redirect is a wrong-path HLT and is dropped.
        if (stall) begin
          pc_d = pc_q;
        end else if (redirect) begin
          pc_d = redirect_target;
        end else if (halt) begin
          state_d = StHalt;
        end else begin
          pc_d = pc_plus1;
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StRun;
          pc_d    = pc_plus1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (clear_stats) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else if (active && branch_valid) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (taken && (taken_cnt_q != '1)) begin
        taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      pc_q         <= RESET_VECTOR;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign flush_if     = redirect;
  assign flush_id     = redirect;
  assign halted       = (state_q == StHalt);
  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit with CNT_W=4 so counter saturation is reachable.
module tb_pc_branch_unit;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, branch_valid, taken, jump, halt, resume, clear_stats;
  logic [ADDR_W-1:0] branch_target, jump_target;
  logic [ADDR_W-1:0] pc, pc_plus1;
  logic              flush_if, flush_id, halted;
  logic [CNT_W-1:0]  branch_count, taken_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_branch_unit #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(10'd0),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_valid (branch_valid),
    .taken        (taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt         (halt),
    .resume       (resume),
    .clear_stats  (clear_stats),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .halted       (halted),
    .branch_count (branch_count),
    .taken_count  (taken_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; branch_valid = 0; taken = 0; jump = 0; halt = 0;
    resume = 0; clear_stats = 0; branch_target = '0; jump_target = '0;
  endtask

  task automatic check_flush(input string tag, input logic exp);
    #1;
    check({tag, "_flush_if"}, {31'd0, flush_if}, {31'd0, exp});
    check({tag, "_flush_id"}, {31'd0, flush_id}, {31'd0, exp});
  endtask

  task automatic check_counts(input string tag, input int b, input int t);
    check({tag, "_branch_count"}, {28'd0, branch_count}, b);
    check({tag, "_taken_count"}, {28'd0, taken_count}, t);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    check("reset_pc", {22'd0, pc}, 0);
    check("reset_halted", {31'd0, halted}, 0);
    check_counts("reset", 0, 0);
    check_flush("reset", 0);
    tick();
    rst = 0;
    check("free_pc0", {22'd0, pc}, 0);
    for (int i = 1; i <= 5; i++) begin
      check_flush("free", 0);
      tick();
      check("free_pc", {22'd0, pc}, i);
    end
    check_counts("free", 0, 0);

    // Taken branch at pc=5.
    branch_valid = 1; taken = 1; branch_target = 10'h40;
    check_flush("br", 1);
    tick();
    idle_inputs();
    check("br_pc", {22'd0, pc}, 32'h40);
    check_counts("br", 1, 1);

    // Branch held under stall for two cycles.
    branch_valid = 1; taken = 1; branch_target = 10'h80; stall = 1;
    for (int i = 0; i < 2; i++) begin
      check_flush("stall", 0);
      tick();
      check("stall_pc", {22'd0, pc}, 32'h40);
      check_counts("stall", 1, 1);
    end
    stall = 0;
    check_flush("unstall", 1);
    tick();
    idle_inputs();
    check("unstall_pc", {22'd0, pc}, 32'h80);
    check_counts("unstall", 2, 2);

    // Jump beats branch; wrong-path halt is dropped.
    jump = 1; jump_target = 10'h10;
    branch_valid = 1; taken = 1; branch_target = 10'h20; halt = 1;
    check_flush("jmp", 1);
    tick();
    idle_inputs();
    check("jmp_pc", {22'd0, pc}, 32'h10);
    check("jmp_halted", {31'd0, halted}, 0);
    check_counts("jmp", 3, 3);

    // Jump to 7 is not counted.
    jump = 1; jump_target = 10'd7;
    tick();
    idle_inputs();
    check("j7_pc", {22'd0, pc}, 7);
    check_counts("j7", 3, 3);

    // Halt at 7, ignore everything for 5 cycles, then resume.
    halt = 1;
    check_flush("halt", 0);
    tick();
    check("halt_halted", {31'd0, halted}, 1);
    check("halt_pc", {22'd0, pc}, 7);
    branch_valid = 1; taken = 1; branch_target = 10'h55; jump = 1; jump_target = 10'h66;
    for (int i = 0; i < 5; i++) begin
      stall = i[0];
      check_flush("halted", 0);
      tick();
      check("halted_pc", {22'd0, pc}, 7);
      check("halted_state", {31'd0, halted}, 1);
    end
    check_counts("halted", 3, 3);
    idle_inputs();
    resume = 1;
    tick();
    idle_inputs();
    check("resume_pc", {22'd0, pc}, 8);
    check("resume_halted", {31'd0, halted}, 0);

    // Saturation with CNT_W=4.
    clear_stats = 1;
    tick();
    idle_inputs();
    check_counts("clr", 0, 0);
    for (int i = 1; i <= 17; i++) begin
      branch_valid = 1; taken = 1; branch_target = 10'h100;
      tick();
      if (i >= 15) check_counts("sat", 15, 15);
    end
    branch_valid = 1; taken = 1; branch_target = 10'h100; clear_stats = 1;
    tick();
    idle_inputs();
    check_counts("sat_clr", 0, 0);

    // Not-taken branch counts only in branch_count.
    branch_valid = 1; taken = 0; branch_target = 10'h200;
    check_flush("nt", 0);
    tick();
    idle_inputs();
    check("nt_pc", {22'd0, pc}, 32'h101);
    check_counts("nt", 1, 0);

    // PC wrap.
    jump = 1; jump_target = 10'h3FF;
    tick();
    idle_inputs();
    check("wrap_plus1", {22'd0, pc_plus1}, 0);
    tick();
    check("wrap_pc", {22'd0, pc}, 0);

    // Back-to-back redirects.
    jump = 1; jump_target = 10'h20;
    check_flush("b2b0", 1);
    tick();
    idle_inputs();
    branch_valid = 1; taken = 1; branch_target = 10'h30;
    check_flush("b2b1", 1);
    tick();
    idle_inputs();
    check("b2b_pc", {22'd0, pc}, 32'h30);

    // Asynchronous reset mid-HALT.
    halt = 1;
    tick();
    idle_inputs();
    check("pre_rst_halted", {31'd0, halted}, 1);
    #2 rst = 1;
    #1;
    check("async_rst_pc", {22'd0, pc}, 0);
    check("async_rst_halted", {31'd0, halted}, 0);
    check_counts("async_rst", 0, 0);
    tick();
    rst = 0;
    tick();
    check("post_rst_pc", {22'd0, pc}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
